tb_ctrl_periph: RTL

Memory-mapped testbench control peripheral on the core's data bus inside the CV32E40P testbench wrapper. It produces the `tests_passed_o`, `tests_failed_o`, `exit_valid_o` and `exit_value_o` signals consumed by the Verilator top level, and buffers firmware character output in a FIFO toward the simulation stdout sink. It also provides a readable cycle counter and a scratch register for firmware self-checks.

---
 rtl/tb_ctrl_periph_if.sv | 24 ++
 rtl/tb_ctrl_periph.sv | 132 +++++++++++++
 2 files changed

// File: rtl/tb_ctrl_periph_if.sv
// Data-bus and stdout-stream signals shared by the testbench control peripheral and its bus master.
interface tb_ctrl_periph_if;
    logic        data_req_i;
    logic        data_gnt_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        stdout_valid_o;
    logic [7:0]  stdout_data_o;
    logic        stdout_ready_i;

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, stdout_ready_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, stdout_valid_o, stdout_data_o
    );

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, stdout_ready_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, stdout_valid_o, stdout_data_o
    );
endinterface

// File: rtl/tb_ctrl_periph.sv
// Testbench control peripheral: status/exit flags, stdout FIFO, cycle counter, scratch register.
// Response 1 cycle after grant; PRINT writes are refused (gnt=0) while the FIFO is full.
module tb_ctrl_periph #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
    input  logic              clk_i,
    input  logic              rst_i,
    tb_ctrl_periph_if.slave   bus,
    output logic              tests_passed_o,
    output logic              tests_failed_o,
    output logic              exit_valid_o,
    output logic [31:0]       exit_value_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [4:0] OFF_PRINT   = 5'h00;
    localparam logic [4:0] OFF_STATUS  = 5'h04;
    localparam logic [4:0] OFF_EXIT    = 5'h08;
    localparam logic [4:0] OFF_CYCLE   = 5'h0C;
    localparam logic [4:0] OFF_SCRATCH = 5'h10;
    localparam logic [4:0] OFF_LEVEL   = 5'h14;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_next;
    logic          fifo_full_q;
    logic [31:0]   cycle_q, scratch_q, rd_val;
    logic          rvalid_q;
    logic [31:0]   rdata_q;

    logic       hit, is_print_write, xfer, wr, push, pop, fifo_empty;
    logic [4:0] off;

    assign hit            = (bus.data_addr_i[31:5] == BASE_ADDR[31:5]);
    assign off            = bus.data_addr_i[4:0];
    assign is_print_write = bus.data_req_i && bus.data_we_i && hit && (off == OFF_PRINT) && bus.data_be_i[0];

    // Uses the registered full flag, so a same-cycle pop never lets a push through.
    assign bus.data_gnt_o = bus.data_req_i && !(is_print_write && fifo_full_q);

    assign xfer       = bus.data_req_i && bus.data_gnt_o;
    assign wr         = xfer && bus.data_we_i;
    assign push       = xfer && is_print_write;
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && bus.stdout_ready_i;

    assign bus.stdout_valid_o = !fifo_empty;
    assign bus.stdout_data_o  = fifo_empty ? 8'h00 : mem[rd_ptr_q];
    assign bus.data_rvalid_o  = rvalid_q;
    assign bus.data_rdata_o   = rdata_q;

    always_comb begin
        count_next = count_q;
        if (push && !pop)
            count_next = count_q + CW'(1);
        else if (pop && !push)
            count_next = count_q - CW'(1);
    end

    always_comb begin
        rd_val = '0;
        if (hit) begin
            case (off)
                OFF_CYCLE:   rd_val = cycle_q;
                OFF_SCRATCH: rd_val = scratch_q;
                OFF_LEVEL:   rd_val = 32'(count_q);
                default:     rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr_q] <= bus.data_wdata_i[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            fifo_full_q    <= 1'b0;
            cycle_q        <= '0;
            scratch_q      <= '0;
            rvalid_q       <= 1'b0;
            rdata_q        <= '0;
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
        end else begin
            cycle_q     <= cycle_q + 32'd1;
            rvalid_q    <= xfer;
            rdata_q     <= (xfer && !bus.data_we_i) ? rd_val : 32'd0;
            count_q     <= count_next;
            fifo_full_q <= (count_next == CW'(FIFO_DEPTH));
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);

            if (wr && hit) begin
                case (off)
                    OFF_STATUS: begin
                        // First verdict wins; later status writes are ignored.
                        if (!tests_passed_o && !tests_failed_o) begin
                            if (bus.data_wdata_i == PASS_MAGIC)
                                tests_passed_o <= 1'b1;
                            else if (bus.data_wdata_i == 32'd1)
                                tests_failed_o <= 1'b1;
                        end
                    end
                    OFF_EXIT: begin
                        if (!exit_valid_o) begin
                            exit_valid_o <= 1'b1;
                            exit_value_o <= bus.data_wdata_i;
                        end
                    end
                    OFF_SCRATCH: begin
                        for (int b = 0; b < 4; b++)
                            if (bus.data_be_i[b])
                                scratch_q[8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
